// File: rtl/lane_merge_rr.sv
// Round-robin merge of NUM_LANES valid/ready streams into one registered, lane-tagged output stream.
// Optional beat counter on the output handshake is enabled with LANE_MERGE_STATS_EN.

module lane_merge_hold #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              hold_vld,
  output logic [DATA_W-1:0] hold_data
);
  // grant only arrives while hold_vld=1, so it never races a fresh accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (grant) begin
      hold_vld  <= 1'b0;
    end else if (in_valid && !hold_vld) begin
      hold_vld  <= 1'b1;
      hold_data <= in_data;
    end
  end
endmodule

module lane_merge_rr #(
  parameter  int NUM_LANES = 3,
  parameter  int DATA_W    = 8,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_LANES-1:0]        in_valid,
  input  logic [NUM_LANES*DATA_W-1:0] in_data,
  output logic [NUM_LANES-1:0]        in_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [LANE_W-1:0]           out_lane,
  input  logic                        out_ready
`ifdef LANE_MERGE_STATS_EN
  ,
  output logic [15:0]                 beat_cnt
`endif
);
  logic [NUM_LANES-1:0]             hold_vld;
  logic [NUM_LANES-1:0][DATA_W-1:0] hold_data;
  logic [NUM_LANES-1:0]             grant;
  logic [LANE_W-1:0]                rr_ptr;
  logic [LANE_W-1:0]                gnt_idx;
  logic                             gnt_any;
  logic                             advance;

  lane_merge_hold #(.DATA_W(DATA_W)) u_hold [NUM_LANES-1:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .grant    (grant),
    .hold_vld (hold_vld),
    .hold_data(hold_data)
  );

  assign in_ready = ~hold_vld;
  assign advance  = ~out_valid | out_ready;

  // first held lane at or after rr_ptr, wrapping
  always_comb begin
    int                idx;
    logic [LANE_W-1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      cand = LANE_W'(idx);
      if (!gnt_any && hold_vld[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_LANES; i++)
      grant[i] = advance && gnt_any && (gnt_idx == LANE_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      rr_ptr    <= '0;
    end else if (advance) begin
      out_valid <= gnt_any;
      if (gnt_any) begin
        out_data <= hold_data[gnt_idx];
        out_lane <= gnt_idx;
        rr_ptr   <= (gnt_idx == LANE_W'(NUM_LANES-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

`ifdef LANE_MERGE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      beat_cnt <= '0;
    else if (out_valid && out_ready && beat_cnt != 16'hFFFF)
      beat_cnt <= beat_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_lane_merge_rr.sv
// Directed + random bench for lane_merge_rr against a cycle-level reference model.
// Build with LANE_MERGE_STATS_EN to also exercise beat_cnt saturation.

module tb_lane_merge_rr;
  localparam int NL = 3;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NL-1:0]   in_valid = '0;
  logic [NL*DW-1:0] in_data = '0;
  logic [NL-1:0]   in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_lane;
  logic            out_ready = 1'b0;
`ifdef LANE_MERGE_STATS_EN
  logic [15:0]     beat_cnt;
`endif

  lane_merge_rr #(.NUM_LANES(NL), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_lane (out_lane),
    .out_ready(out_ready)
`ifdef LANE_MERGE_STATS_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit        m_hv[NL];
  logic [7:0] m_hd[NL];
  bit        m_ov;
  logic [7:0] m_od;
  int        m_ol;
  int        m_rr;
  int        m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin m_hv[i] = 0; m_hd[i] = '0; end
    m_ov = 0; m_od = '0; m_ol = 0; m_rr = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit acc[NL];
    int g;
    for (int i = 0; i < NL; i++) acc[i] = in_valid[i] && !m_hv[i];
    if (m_ov && out_ready && m_cnt < 65535) m_cnt++;
    if (!m_ov || out_ready) begin
      g = -1;
      for (int k = 0; k < NL; k++)
        if (g < 0 && m_hv[(m_rr + k) % NL]) g = (m_rr + k) % NL;
      if (g >= 0) begin
        m_ov = 1; m_od = m_hd[g]; m_ol = g; m_hv[g] = 0; m_rr = (g + 1) % NL;
      end else m_ov = 0;
    end
    for (int i = 0; i < NL; i++)
      if (acc[i]) begin m_hv[i] = 1; m_hd[i] = in_data[i*DW +: DW]; end
  endtask

  task automatic check_model();
    logic [NL-1:0] exp_rdy;
    for (int i = 0; i < NL; i++) exp_rdy[i] = !m_hv[i];
    chk("m_out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("m_out_data", 32'(out_data), 32'(m_od));
      chk("m_out_lane", 32'(out_lane), 32'(m_ol));
    end
    chk("m_in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef LANE_MERGE_STATS_EN
    chk("m_beat_cnt", 32'(beat_cnt), 32'(m_cnt));
`endif
  endtask

  // one clock: model follows the edge with the inputs the DUT saw, compare at negedge
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // reset with all lanes requesting
    in_valid = 3'b111; in_data = {8'h33, 8'h22, 8'h11}; out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 32'h7);
      chk("rst_out_lane", 32'(out_lane), 0);
    end
    rst_n = 1'b1;

    // single beat on lane 1
    in_valid = 3'b010; in_data = {8'h00, 8'hA5, 8'h00};
    cyc();
    in_valid = 3'b000;
    cyc();
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_lane", 32'(out_lane), 1);
    cyc(); cyc();

    // all lanes streaming, expect gapless 0,1,2 rotation
    do_reset();
    in_valid = 3'b111; in_data = {8'h12, 8'h11, 8'h10}; out_ready = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      if (n >= 2) begin
        chk("rr_valid", 32'(out_valid), 1);
        chk("rr_lane", 32'(out_lane), 32'((n - 2) % 3));
        chk("rr_data", 32'(out_data), 32'(8'h10 + (n - 2) % 3));
      end
    end
    in_valid = '0;
    for (int n = 0; n < 4; n++) cyc();

    // backpressure with C3 parked on the output
    do_reset();
    in_valid = 3'b111; in_data = {8'hC5, 8'hC4, 8'hC3}; out_ready = 1'b0;
    cyc(); cyc(); cyc();
    in_valid = '0;
    for (int n = 0; n < 5; n++) begin
      cyc();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'hC3);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    cyc(); chk("bp_rel1_lane", 32'(out_lane), 1); chk("bp_rel1_data", 32'(out_data), 32'hC4);
    cyc(); chk("bp_rel2_lane", 32'(out_lane), 2); chk("bp_rel2_data", 32'(out_data), 32'hC5);
    cyc(); chk("bp_rel3_lane", 32'(out_lane), 0); chk("bp_rel3_data", 32'(out_data), 32'hC3);
    cyc(); chk("bp_drained", 32'(out_valid), 0);

    // asynchronous reset while output and two lanes are occupied
    do_reset();
    in_valid = 3'b011; in_data = {8'h00, 8'h5B, 8'h5A}; out_ready = 1'b0;
    cyc(); cyc(); cyc();
    chk("mid_pre_valid", 32'(out_valid), 1);
    chk("mid_pre_ready", 32'(in_ready), 32'h4);
    #2 rst_n = 1'b0; in_valid = '0;
    #1;
    model_reset();
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_out_data", 32'(out_data), 0);
    chk("mid_out_lane", 32'(out_lane), 0);
    chk("mid_in_ready", 32'(in_ready), 32'h7);
    cyc();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cyc();
      chk("mid_no_stale", 32'(out_valid), 0);
    end

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      in_valid  = NL'($urandom_range(0, 7));
      in_data   = (NL*DW)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

`ifdef LANE_MERGE_STATS_EN
    do_reset();
    in_valid = 3'b111; out_ready = 1'b1;
    for (int n = 0; n < 70010; n++) begin
      in_data = (NL*DW)'($urandom);
      cyc();
    end
    chk("stats_sat", 32'(beat_cnt), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
